// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: plays one of four fixed note sequences into a buzzer note input.
// Optional macro SFX_PREEMPT_EN lets a new play request abort the running effect.
module sfx_sequencer #(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned TICK_HZ  = 50
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_play,
  input  logic [1:0] i_sfx_sel,
  output logic [5:0] o_music_scale,
  output logic       o_busy,
  output logic       o_done
);

  localparam int unsigned TICK_CYCLES = CLK_FREQ / TICK_HZ;
  localparam int unsigned PRE_W       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

`ifdef SFX_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  if (TICK_CYCLES < 1) begin : g_bad_tick
    $error("sfx_sequencer: CLK_FREQ/TICK_HZ must be at least 1");
  end

  typedef enum logic {S_IDLE, S_PLAY} state_e;

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [4:0]       idx_q, idx_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [3:0]       tick_q, tick_d;
  logic [5:0]       scale_q, scale_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [5:0]       ent_scale;
  logic [3:0]       ent_dur;

  // Effect table; index 16 (past the last entry) reads as an end marker so the index never wraps.
  always_comb begin
    ent_scale = 6'd0;
    ent_dur   = 4'd0;
    if (!idx_q[4]) begin
      unique case (sel_q)
        2'd0: case (idx_q[3:0])
          4'd0:    begin ent_scale = 6'd15; ent_dur = 4'd2; end
          4'd1:    begin ent_scale = 6'd22; ent_dur = 4'd3; end
          default: begin ent_scale = 6'd0;  ent_dur = 4'd0; end
        endcase
        2'd1: case (idx_q[3:0])
          4'd0:    begin ent_scale = 6'd10; ent_dur = 4'd2; end
          4'd1:    begin ent_scale = 6'd0;  ent_dur = 4'd1; end
          4'd2:    begin ent_scale = 6'd8;  ent_dur = 4'd2; end
          default: begin ent_scale = 6'd0;  ent_dur = 4'd0; end
        endcase
        2'd2: case (idx_q[3:0])
          4'd0:    begin ent_scale = 6'd22; ent_dur = 4'd1; end
          4'd1:    begin ent_scale = 6'd24; ent_dur = 4'd1; end
          4'd2:    begin ent_scale = 6'd26; ent_dur = 4'd2; end
          default: begin ent_scale = 6'd0;  ent_dur = 4'd0; end
        endcase
        default: case (idx_q[3:0])
          4'd0:    begin ent_scale = 6'd20; ent_dur = 4'd3; end
          4'd1:    begin ent_scale = 6'd17; ent_dur = 4'd3; end
          4'd2:    begin ent_scale = 6'd13; ent_dur = 4'd6; end
          default: begin ent_scale = 6'd0;  ent_dur = 4'd0; end
        endcase
      endcase
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    pre_d   = pre_q;
    tick_d  = tick_q;
    scale_d = scale_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        scale_d = 6'd0;
        busy_d  = 1'b0;
        if (i_play) begin
          state_d = S_PLAY;
          sel_d   = i_sfx_sel;
          idx_d   = 5'd0;
          pre_d   = '0;
          tick_d  = 4'd0;
        end
      end
      default: begin
        if (PREEMPT && i_play) begin
          sel_d  = i_sfx_sel;
          idx_d  = 5'd0;
          pre_d  = '0;
          tick_d = 4'd0;
        end else if (ent_dur == 4'd0) begin
          state_d = S_IDLE;
          scale_d = 6'd0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          idx_d   = 5'd0;
          pre_d   = '0;
          tick_d  = 4'd0;
        end else begin
          scale_d = ent_scale;
          busy_d  = 1'b1;
          if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (tick_q == ent_dur - 4'd1) begin
              tick_d = 4'd0;
              idx_d  = idx_q + 5'd1;
            end else begin
              tick_d = tick_q + 4'd1;
            end
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sel_q   <= 2'd0;
      idx_q   <= 5'd0;
      pre_q   <= '0;
      tick_q  <= 4'd0;
      scale_q <= 6'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      scale_q <= scale_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_music_scale = scale_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Self-checking bench for sfx_sequencer: vector table, trace model, random effects, corner cases.
module tb_sfx_sequencer;

  localparam int TICK = 10;

  logic       clk;
  logic       rst_n;
  logic       i_play;
  logic [1:0] i_sfx_sel;
  logic [5:0] o_music_scale;
  logic       o_busy;
  logic       o_done;

  int tests;
  int fails;

  int tbl_scale [4][16];
  int tbl_dur   [4][16];
  logic [7:0] exp_q[$];

  typedef struct {
    int         sel;
    int         off;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[$];

  sfx_sequencer #(.CLK_FREQ(1000), .TICK_HZ(100)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_play       (i_play),
    .i_sfx_sel    (i_sfx_sel),
    .o_music_scale(o_music_scale),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = {o_music_scale, o_busy, o_done};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got scale=%0d busy=%0b done=%0b, want scale=%0d busy=%0b done=%0b",
               name, act[7:2], act[1], act[0], exp[7:2], exp[1], exp[0]);
    end
  endtask

  task automatic set_entry(input int s, input int e, input int sc, input int d);
    tbl_scale[s][e] = sc;
    tbl_dur[s][e]   = d;
  endtask

  task automatic init_tbl();
    for (int s = 0; s < 4; s++)
      for (int e = 0; e < 16; e++) set_entry(s, e, 0, 0);
    set_entry(0, 0, 15, 2); set_entry(0, 1, 22, 3);
    set_entry(1, 0, 10, 2); set_entry(1, 1, 0, 1);  set_entry(1, 2, 8, 2);
    set_entry(2, 0, 22, 1); set_entry(2, 1, 24, 1); set_entry(2, 2, 26, 2);
    set_entry(3, 0, 20, 3); set_entry(3, 1, 17, 3); set_entry(3, 2, 13, 6);
  endtask

  // Per-cycle outputs from edge N+1 onward for an effect accepted at edge N.
  function automatic void push_effect(input int sel);
    for (int e = 0; e < 16; e++) begin
      if (tbl_dur[sel][e] == 0) break;
      for (int c = 0; c < tbl_dur[sel][e] * TICK; c++)
        exp_q.push_back({6'(tbl_scale[sel][e]), 2'b10});
    end
    exp_q.push_back(8'b0000_0001);
  endfunction

  function automatic void add_vec(input int sel, input int off, input int sc, input logic b, input logic d);
    vec_t v;
    v.sel = sel;
    v.off = off;
    v.exp = {6'(sc), b, d};
    vecs.push_back(v);
  endfunction

  task automatic start(input int sel);
    i_sfx_sel = 2'(sel);
    i_play    = 1'b1;
    tick();
    i_play    = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      if (!o_busy && !o_done) ok = 1'b1;
      else tick();
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: still busy after 300 cycles, required idle");
    end
  endtask

  task automatic run_queue(input string name);
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      check(name, e);
    end
  endtask

  initial begin
    int ndone;
    logic [7:0] e;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    i_play = 1'b0;
    i_sfx_sel = 2'd0;
    init_tbl();

    #2;
    check("reset_state", 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", 8'h00);

    // Table-driven spot checks at fixed offsets from the accepting edge.
    add_vec(0, 1, 15, 1, 0); add_vec(0, 20, 15, 1, 0); add_vec(0, 21, 22, 1, 0);
    add_vec(0, 50, 22, 1, 0); add_vec(0, 51, 0, 0, 1); add_vec(0, 52, 0, 0, 0);
    add_vec(1, 1, 10, 1, 0); add_vec(1, 20, 10, 1, 0); add_vec(1, 21, 0, 1, 0);
    add_vec(1, 30, 0, 1, 0); add_vec(1, 31, 8, 1, 0); add_vec(1, 50, 8, 1, 0);
    add_vec(1, 51, 0, 0, 1);
    add_vec(2, 10, 22, 1, 0); add_vec(2, 11, 24, 1, 0); add_vec(2, 21, 26, 1, 0);
    add_vec(2, 41, 0, 0, 1);
    add_vec(3, 30, 20, 1, 0); add_vec(3, 31, 17, 1, 0); add_vec(3, 61, 13, 1, 0);
    add_vec(3, 120, 13, 1, 0); add_vec(3, 121, 0, 0, 1);
    foreach (vecs[i]) begin
      wait_idle();
      start(vecs[i].sel);
      check("vec_accept_edge", 8'h00);
      repeat (vecs[i].off) tick();
      check($sformatf("vec%0d_sel%0d_off%0d", i, vecs[i].sel, vecs[i].off), vecs[i].exp);
      wait_idle();
    end

    // Random effects with gaps; stray play requests mid-effect must be ignored.
    for (int it = 0; it < 20; it++) begin
      int sel;
      int gap;
      sel = int'($urandom_range(0, 3));
      gap = int'($urandom_range(0, 5));
      repeat (gap) begin
        tick();
        check("rand_gap", 8'h00);
      end
      exp_q.delete();
      push_effect(sel);
      start(sel);
      check("rand_accept", 8'h00);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
`ifndef SFX_PREEMPT_EN
        i_play    = ($urandom_range(0, 3) == 0);
        i_sfx_sel = 2'($urandom_range(0, 3));
`endif
        tick();
        check($sformatf("rand%0d_sel%0d", it, sel), e);
      end
      i_play = 1'b0;
    end

    // Play request during gameover at edge N+15.
    wait_idle();
    exp_q.delete();
    push_effect(3);
`ifdef SFX_PREEMPT_EN
    exp_q = exp_q[0:14];
    push_effect(2);
`endif
    start(3);
    for (int j = 1; exp_q.size() > 0; j++) begin
      e = exp_q.pop_front();
      if (j == 15) begin
        i_sfx_sel = 2'd2;
        i_play    = 1'b1;
      end
      tick();
      i_play = 1'b0;
      check($sformatf("preempt_edge%0d", j), e);
    end

    // Reset mid-effect, then a clean replay.
    wait_idle();
    start(0);
    repeat (6) tick();
    check("jump_before_reset", {6'd15, 2'b10});
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_immediate", 8'h00);
    tick();
    check("reset_held", 8'h00);
    rst_n = 1'b1;
    tick();
    check("reset_released", 8'h00);
    exp_q.delete();
    push_effect(0);
    start(0);
    check("replay_accept", 8'h00);
    run_queue("replay_jump");

`ifndef SFX_PREEMPT_EN
    // Held play: score repeats, each pass re-accepted on the edge after o_done.
    wait_idle();
    exp_q.delete();
    for (int p = 0; p < 3; p++) begin
      exp_q.push_back(8'h00);
      push_effect(2);
    end
    ndone = 0;
    i_sfx_sel = 2'd2;
    i_play    = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (exp_q.size() == 0) i_play = 1'b0;
      tick();
      if (o_done) ndone++;
      check("held_play", e);
    end
    i_play = 1'b0;
    tests++;
    if (ndone != 3) begin
      fails++;
      $display("FAIL held_play_done_count: got %0d pulses, want 3", ndone);
    end
    tick();
    check("held_play_end_idle", 8'h00);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
